// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch requester, the data requester and the shared memory port
// seen by mem_port_arbiter.
//   master : the arbiter's view. It drives the grants, the response valids and
//            data, the memory request fields and stray_rsp.
//   slave  : the environment's view (requesters plus memory), mirrored.
// Signal groups:
//   if_*   instruction fetch (req/addr/flush in, gnt/rvalid/rdata out)
//   d_*    load/store (req/we/be/addr/wdata in, gnt/rvalid/rdata out)
//   m_*    memory (req/we/be/addr/wdata out, gnt/rvalid/rdata in)
//   stray_rsp  one-cycle pulse for a memory response that has no owner
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [BE_W-1:0]   d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              m_req;
    logic              m_we;
    logic [BE_W-1:0]   m_be;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_gnt;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;

    logic              stray_rsp;

    modport master (
        input  if_req, if_addr, if_flush,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_be, m_addr, m_wdata,
        input  m_gnt, m_rvalid, m_rdata,
        output stray_rsp
    );

    modport slave (
        output if_req, if_addr, if_flush,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_be, m_addr, m_wdata,
        output m_gnt, m_rvalid, m_rdata,
        input  stray_rsp
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between instruction fetch and load/store with
// a single transaction outstanding. Data has priority, but after STREAK_MAX
// consecutive data grants taken while fetch was asking, fetch is forced
// through. Responses are routed combinationally to the owner. A flushed fetch
// has its response swallowed. A response arriving with nothing outstanding
// raises stray_rsp.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high. While it is high every output is 0,
//          except the rdata buses, which always mirror m_rdata.
//   bus    mem_port_arbiter_if.master (fetch, data and memory groups)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STREAK_MAX = 4
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.master bus
);
    localparam int BE_W     = DATA_W / 8;
    localparam int STREAK_W = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(STREAK_MAX);
    localparam logic [STREAK_W-1:0] STREAK_ONE   = STREAK_W'(1);
    localparam logic [STREAK_W-1:0] STREAK_ZERO  = STREAK_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_F = 2'd1,
        ST_WAIT_D = 2'd2,
        ST_DROP   = 2'd3
    } state_e;

    state_e              state_r;
    state_e              state_nxt_s;
    logic [STREAK_W-1:0] streak_r;
    logic [STREAK_W-1:0] streak_nxt_s;
    logic                f_elig_s;
    logic                d_elig_s;
    logic                pick_f_s;

    // Eligibility and winner selection for an issue slot in IDLE.
    always_comb begin
        // A flush masks fetch even in the cycle it would otherwise be granted.
        f_elig_s = bus.if_req & ~bus.if_flush;
        d_elig_s = bus.d_req;
        if (f_elig_s && (!d_elig_s || (streak_r >= STREAK_LIMIT))) begin
            pick_f_s = 1'b1;
        end else begin
            pick_f_s = 1'b0;
        end
    end

    // Next-state, streak update and all bus outputs.
    always_comb begin
        state_nxt_s   = state_r;
        streak_nxt_s  = streak_r;
        bus.if_gnt    = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = bus.m_rdata;
        bus.d_gnt     = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = bus.m_rdata;
        bus.m_req     = 1'b0;
        bus.m_we      = 1'b0;
        bus.m_be      = {BE_W{1'b0}};
        bus.m_addr    = {ADDR_W{1'b0}};
        bus.m_wdata   = {DATA_W{1'b0}};
        bus.stray_rsp = 1'b0;

        if (reset) begin
            // Any in-flight transaction is abandoned. Its late response will
            // show up as stray_rsp.
            state_nxt_s  = ST_IDLE;
            streak_nxt_s = STREAK_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    bus.stray_rsp = bus.m_rvalid;
                    if (f_elig_s || d_elig_s) begin
                        bus.m_req = 1'b1;
                        if (pick_f_s) begin
                            bus.m_be   = {BE_W{1'b1}};
                            bus.m_addr = bus.if_addr;
                        end else begin
                            bus.m_we    = bus.d_we;
                            bus.m_be    = bus.d_be;
                            bus.m_addr  = bus.d_addr;
                            bus.m_wdata = bus.d_wdata;
                        end
                        if (bus.m_gnt) begin
                            if (pick_f_s) begin
                                bus.if_gnt   = 1'b1;
                                state_nxt_s  = ST_WAIT_F;
                                streak_nxt_s = STREAK_ZERO;
                            end else begin
                                bus.d_gnt   = 1'b1;
                                state_nxt_s = ST_WAIT_D;
                                // Count only data grants that made a fetch wait.
                                if (bus.if_req) begin
                                    if (streak_r >= STREAK_LIMIT) begin
                                        streak_nxt_s = STREAK_LIMIT;
                                    end else begin
                                        streak_nxt_s = streak_r + STREAK_ONE;
                                    end
                                end else begin
                                    streak_nxt_s = STREAK_ZERO;
                                end
                            end
                        end else begin
                            // Memory stalled. Nothing is latched, so the
                            // winner is re-evaluated next cycle.
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_WAIT_D: begin
                    if (bus.m_rvalid) begin
                        bus.d_rvalid = 1'b1;
                        state_nxt_s  = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_WAIT_D;
                    end
                end
                ST_WAIT_F: begin
                    if (bus.m_rvalid) begin
                        // A flush in the response cycle still kills the data.
                        bus.if_rvalid = ~bus.if_flush;
                        state_nxt_s   = ST_IDLE;
                    end else if (bus.if_flush) begin
                        state_nxt_s = ST_DROP;
                    end else begin
                        state_nxt_s = ST_WAIT_F;
                    end
                end
                ST_DROP: begin
                    if (bus.m_rvalid) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DROP;
                    end
                end
                default: begin
                    state_nxt_s  = ST_IDLE;
                    streak_nxt_s = STREAK_ZERO;
                end
            endcase
        end
    end

    // State and streak registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            streak_r <= STREAK_ZERO;
        end else begin
            state_r  <= state_nxt_s;
            streak_r <= streak_nxt_s;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int BE_W       = 4;
    localparam int STREAK_MAX = 4;
    localparam int T_F = 1;  // outstanding fetch
    localparam int T_D = 2;  // outstanding data access
    localparam int T_X = 3;  // outstanding fetch that was flushed

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STREAK_MAX(STREAK_MAX)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    // Reference model: the list of outstanding transactions and the number of
    // consecutive data grants taken while fetch was asking.
    int q_m[$];
    int streak_m;
    bit granted_m;
    int glog[$];

    // Memory responder used in the automatic phases.
    bit mem_auto;
    bit mem_pend;
    int mem_cnt;
    int mem_lat_max;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic eval_and_check();
        logic            e_if_gnt, e_if_rvalid, e_d_gnt, e_d_rvalid, e_m_req, e_m_we, e_stray;
        logic [BE_W-1:0] e_m_be;
        logic [31:0]     e_m_addr, e_m_wdata;
        bit              fe, de, fwin;
        @(negedge clock);
        e_if_gnt = 1'b0; e_if_rvalid = 1'b0; e_d_gnt = 1'b0; e_d_rvalid = 1'b0;
        e_m_req = 1'b0; e_m_we = 1'b0; e_stray = 1'b0;
        e_m_be = 4'h0; e_m_addr = 32'h0; e_m_wdata = 32'h0;
        granted_m = 1'b0;
        if (reset) begin
            q_m.delete();
            streak_m = 0;
        end else if (q_m.size() == 0) begin
            e_stray = bus.m_rvalid;
            fe = bus.if_req && !bus.if_flush;
            de = bus.d_req;
            if (fe || de) begin
                fwin = fe && (!de || streak_m >= STREAK_MAX);
                e_m_req = 1'b1;
                if (fwin) begin
                    e_m_be = 4'hF; e_m_addr = bus.if_addr;
                end else begin
                    e_m_we = bus.d_we; e_m_be = bus.d_be;
                    e_m_addr = bus.d_addr; e_m_wdata = bus.d_wdata;
                end
                if (bus.m_gnt) begin
                    granted_m = 1'b1;
                    if (fwin) begin
                        e_if_gnt = 1'b1; q_m.push_back(T_F); streak_m = 0;
                    end else begin
                        e_d_gnt = 1'b1; q_m.push_back(T_D);
                        if (bus.if_req) streak_m = (streak_m + 1 > STREAK_MAX) ? STREAK_MAX : streak_m + 1;
                        else streak_m = 0;
                    end
                end
            end
        end else begin
            if (q_m[0] == T_F && bus.if_flush) q_m[0] = T_X;
            if (bus.m_rvalid) begin
                if (q_m[0] == T_F) e_if_rvalid = 1'b1;
                if (q_m[0] == T_D) e_d_rvalid = 1'b1;
                void'(q_m.pop_front());
            end
        end
        chk("if_gnt", bus.if_gnt, e_if_gnt);
        chk("if_rvalid", bus.if_rvalid, e_if_rvalid);
        chk("if_rdata", bus.if_rdata, bus.m_rdata);
        chk("d_gnt", bus.d_gnt, e_d_gnt);
        chk("d_rvalid", bus.d_rvalid, e_d_rvalid);
        chk("d_rdata", bus.d_rdata, bus.m_rdata);
        chk("m_req", bus.m_req, e_m_req);
        chk("m_we", bus.m_we, e_m_we);
        chk("m_be", bus.m_be, e_m_be);
        chk("m_addr", bus.m_addr, e_m_addr);
        chk("m_wdata", bus.m_wdata, e_m_wdata);
        chk("stray_rsp", bus.stray_rsp, e_stray);
        if (bus.if_gnt === 1'b1) glog.push_back(T_F);
        if (bus.d_gnt === 1'b1) glog.push_back(T_D);
    endtask

    task automatic advance();
        if (mem_auto) begin
            if (bus.m_rvalid) mem_pend = 1'b0;
            else if (mem_pend && mem_cnt > 0) mem_cnt--;
            if (granted_m) begin
                mem_pend = 1'b1;
                mem_cnt  = int'($urandom_range(mem_lat_max - 1, 0));
            end
        end
        @(posedge clock);
        #1;
        if (mem_auto) begin
            bus.m_rvalid = mem_pend && (mem_cnt == 0);
            bus.m_rdata  = $urandom;
        end
    endtask

    task automatic tick();
        eval_and_check();
        advance();
    endtask

    task automatic clear_inputs();
        bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.if_flush = 1'b0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0;
        bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        bus.m_gnt = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = 32'h0;
    endtask

    initial begin
        int g;
        reset = 1'b1;
        mem_auto = 1'b0; mem_pend = 1'b0; mem_cnt = 0; mem_lat_max = 1;
        streak_m = 0;
        clear_inputs();
        @(posedge clock); #1;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        tick();

        // Single fetch with a 3-cycle memory
        bus.if_req = 1'b1; bus.if_addr = 32'h10; bus.m_gnt = 1'b1;
        eval_and_check();
        chk("tp_fetch_gnt", bus.if_gnt, 32'd1);
        advance();
        bus.if_req = 1'b0; bus.m_gnt = 1'b0;
        tick(); tick();
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'h00500093;
        eval_and_check();
        chk("tp_fetch_rvalid", bus.if_rvalid, 32'd1);
        chk("tp_fetch_rdata", bus.if_rdata, 32'h00500093);
        advance();
        bus.m_rvalid = 1'b0;
        tick();

        // Write
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011;
        bus.d_addr = 32'h200; bus.d_wdata = 32'hDEADBEEF; bus.m_gnt = 1'b1;
        eval_and_check();
        chk("tp_wr_m_we", bus.m_we, 32'd1);
        chk("tp_wr_m_be", bus.m_be, 32'h3);
        chk("tp_wr_m_addr", bus.m_addr, 32'h200);
        chk("tp_wr_m_wdata", bus.m_wdata, 32'hDEADBEEF);
        advance();
        clear_inputs();
        bus.m_rvalid = 1'b1;
        eval_and_check();
        chk("tp_wr_ack", bus.d_rvalid, 32'd1);
        advance();
        bus.m_rvalid = 1'b0;

        // Flush one cycle after a fetch grant, response two cycles later
        bus.if_req = 1'b1; bus.if_addr = 32'h20; bus.m_gnt = 1'b1;
        tick();
        bus.if_req = 1'b0; bus.m_gnt = 1'b0; bus.if_flush = 1'b1;
        tick();
        bus.if_flush = 1'b0;
        tick();
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'hCAFE0001;
        eval_and_check();
        chk("tp_flush_no_rvalid", bus.if_rvalid, 32'd0);
        advance();
        bus.m_rvalid = 1'b0;
        bus.d_req = 1'b1; bus.d_addr = 32'h300; bus.d_be = 4'hF; bus.m_gnt = 1'b1;
        eval_and_check();
        chk("tp_flush_next_dgnt", bus.d_gnt, 32'd1);
        advance();
        clear_inputs();
        bus.m_rvalid = 1'b1;
        tick();
        bus.m_rvalid = 1'b0;

        // Flush coinciding with the response
        bus.if_req = 1'b1; bus.if_addr = 32'h24; bus.m_gnt = 1'b1;
        tick();
        clear_inputs();
        bus.if_flush = 1'b1; bus.m_rvalid = 1'b1;
        eval_and_check();
        chk("flush_rsp_same_cycle", bus.if_rvalid, 32'd0);
        advance();
        clear_inputs();

        // Flush masks a fetch grant in the same cycle
        bus.if_req = 1'b1; bus.if_flush = 1'b1; bus.if_addr = 32'h28; bus.m_gnt = 1'b1;
        eval_and_check();
        chk("flush_mask_req", bus.m_req, 32'd0);
        chk("flush_mask_gnt", bus.if_gnt, 32'd0);
        advance();
        clear_inputs();

        // Memory stall for 5 cycles, fetch arrives at cycle 3
        bus.d_req = 1'b1; bus.d_addr = 32'h400; bus.d_be = 4'hF;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin bus.if_req = 1'b1; bus.if_addr = 32'h44; end
            eval_and_check();
            chk("stall_m_req", bus.m_req, 32'd1);
            chk("stall_d_gnt", bus.d_gnt, 32'd0);
            advance();
        end
        bus.m_gnt = 1'b1;
        eval_and_check();
        chk("stall_dgnt", bus.d_gnt, 32'd1);
        advance();
        bus.d_req = 1'b0; bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1;
        tick();
        bus.m_rvalid = 1'b0; bus.m_gnt = 1'b1;
        eval_and_check();
        chk("stall_fetch_follows", bus.if_gnt, 32'd1);
        advance();
        clear_inputs();
        bus.m_rvalid = 1'b1;
        tick();
        bus.m_rvalid = 1'b0;

        // Contention with a 1-cycle memory: four data grants, then fetch
        mem_auto = 1'b1; mem_lat_max = 1; mem_pend = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100; bus.d_be = 4'hF;
        bus.if_req = 1'b1; bus.if_addr = 32'h80; bus.m_gnt = 1'b1;
        glog.delete();
        repeat (12) tick();
        chk("contention_ngrants", glog.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            g = (i < glog.size()) ? glog[i] : 0;
            chk($sformatf("contention_grant%0d", i), g, (i == 4) ? T_F : T_D);
        end
        clear_inputs();
        mem_auto = 1'b0; mem_pend = 1'b0;
        tick();

        // Reset in WAIT_D, response after release
        bus.d_req = 1'b1; bus.d_addr = 32'h500; bus.d_be = 4'hF; bus.m_gnt = 1'b1;
        tick();
        bus.if_req = 1'b1; reset = 1'b1;
        eval_and_check();
        chk("rst_m_req_zero", bus.m_req, 32'd0);
        chk("rst_gnt_zero", {bus.if_gnt, bus.d_gnt}, 32'd0);
        advance();
        reset = 1'b0;
        clear_inputs();
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'h1234;
        eval_and_check();
        chk("rst_late_d_rvalid", bus.d_rvalid, 32'd0);
        chk("rst_late_stray", bus.stray_rsp, 32'd1);
        advance();
        bus.m_rvalid = 1'b0;
        tick();

        // Randomized traffic with a 1..4 cycle memory
        mem_auto = 1'b1; mem_lat_max = 4; mem_pend = 1'b0; bus.m_rvalid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            bus.if_req   = ($urandom_range(1, 0) == 1);
            bus.if_addr  = $urandom & 32'hFFFF_FFFC;
            bus.if_flush = ($urandom_range(7, 0) == 0);
            bus.d_req    = ($urandom_range(3, 0) != 0);
            bus.d_we     = ($urandom_range(1, 0) == 1);
            bus.d_be     = 4'($urandom);
            bus.d_addr   = $urandom;
            bus.d_wdata  = $urandom;
            bus.m_gnt    = ($urandom_range(3, 0) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
